// File: rtl/iiitb_brg_prog.sv
// Programmable fractional baud-rate generator: oversample tick, bit tick and 50% baud clock.
// The divisor comes from a preset table or custom ports and changes only on bit boundaries.
module iiitb_brg_prog #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16,
  parameter logic [DIV_W+FRAC_W-1:0] PRESET0 = {16'd325, 4'd8},
  parameter logic [DIV_W+FRAC_W-1:0] PRESET1 = {16'd162, 4'd12},
  parameter logic [DIV_W+FRAC_W-1:0] PRESET2 = {16'd27,  4'd2}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        sel,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              cfg_load,
  output logic              cfg_busy,
  output logic              cfg_ack,
  output logic              ovs_tick,
  output logic              bit_tick,
  output logic              clkout,
  output logic              div_err
);

  localparam int OVS_W = $clog2(OVS);

  logic [DIV_W-1:0]  in_int, act_int_q, act_int_d, shadow_int_q, shadow_int_d, cur_int;
  logic [FRAC_W-1:0] in_frac, act_frac_q, act_frac_d, shadow_frac_q, shadow_frac_d, cur_frac;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;
  logic [DIV_W:0]    cnt_q, cnt_d, period;
  logic [OVS_W-1:0]  ovs_cnt_q, ovs_cnt_d;
  logic              in_bad, shadow_bad_q, shadow_bad_d;
  logic              busy_q, busy_d, ack_q, ack_d, err_q, err_d, init_q, init_d;
  logic              ovs_tick_q, ovs_tick_d, bit_tick_q, bit_tick_d, clkout_q, clkout_d;
  logic              period_end, wrap, apply;

  // Presets pass through untouched; only a custom integer divisor below 2 is clamped.
  always_comb begin
    in_int  = div_int;
    in_frac = div_frac;
    in_bad  = 1'b0;
    case (sel)
      2'b00:   {in_int, in_frac} = PRESET0;
      2'b01:   {in_int, in_frac} = PRESET1;
      2'b10:   {in_int, in_frac} = PRESET2;
      default: begin
        if (div_int < DIV_W'(2)) begin
          in_int = DIV_W'(2);
          in_bad = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    act_int_d     = act_int_q;
    act_frac_d    = act_frac_q;
    shadow_int_d  = shadow_int_q;
    shadow_frac_d = shadow_frac_q;
    shadow_bad_d  = shadow_bad_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    ovs_cnt_d     = ovs_cnt_q;
    busy_d        = busy_q;
    err_d         = err_q;
    init_d        = init_q;
    clkout_d      = clkout_q;
    ack_d         = 1'b0;
    ovs_tick_d    = 1'b0;
    bit_tick_d    = 1'b0;

    // Until the first edge after reset the inputs themselves are the active divisor.
    cur_int    = init_q ? act_int_q  : in_int;
    cur_frac   = init_q ? act_frac_q : in_frac;
    sum        = {1'b0, acc_q} + {1'b0, cur_frac};
    period     = {1'b0, cur_int} + {{DIV_W{1'b0}}, sum[FRAC_W]};
    period_end = en && (cnt_q == period - (DIV_W+1)'(1));
    wrap       = period_end && (ovs_cnt_q == OVS_W'(OVS - 1));
    apply      = busy_q && (wrap || !en);

    if (!init_q) begin
      act_int_d  = in_int;
      act_frac_d = in_frac;
      err_d      = err_q | in_bad;
      init_d     = 1'b1;
    end

    if (en) begin
      if (period_end) begin
        cnt_d      = '0;
        acc_d      = sum[FRAC_W-1:0];
        ovs_tick_d = 1'b1;
        bit_tick_d = wrap;
        ovs_cnt_d  = wrap ? '0 : ovs_cnt_q + OVS_W'(1);
        if (wrap || ovs_cnt_q == OVS_W'(OVS/2 - 1))
          clkout_d = ~clkout_q;
      end else begin
        cnt_d = cnt_q + (DIV_W+1)'(1);
      end
    end else begin
      cnt_d     = '0;
      acc_d     = '0;
      ovs_cnt_d = '0;
      clkout_d  = 1'b0;
    end

    // The shadow takes effect only at a bit boundary, so a running bit is never cut short.
    if (apply) begin
      act_int_d  = shadow_int_q;
      act_frac_d = shadow_frac_q;
      err_d      = err_q | shadow_bad_q;
      acc_d      = '0;
      ack_d      = 1'b1;
      busy_d     = 1'b0;
    end

    if (cfg_load) begin
      shadow_int_d  = in_int;
      shadow_frac_d = in_frac;
      shadow_bad_d  = in_bad;
      busy_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_int_q     <= '0;
      act_frac_q    <= '0;
      shadow_int_q  <= '0;
      shadow_frac_q <= '0;
      shadow_bad_q  <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      ovs_cnt_q     <= '0;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      init_q        <= 1'b0;
      ovs_tick_q    <= 1'b0;
      bit_tick_q    <= 1'b0;
      clkout_q      <= 1'b0;
    end else begin
      act_int_q     <= act_int_d;
      act_frac_q    <= act_frac_d;
      shadow_int_q  <= shadow_int_d;
      shadow_frac_q <= shadow_frac_d;
      shadow_bad_q  <= shadow_bad_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ovs_cnt_q     <= ovs_cnt_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      init_q        <= init_d;
      ovs_tick_q    <= ovs_tick_d;
      bit_tick_q    <= bit_tick_d;
      clkout_q      <= clkout_d;
    end
  end

  assign cfg_busy = busy_q;
  assign cfg_ack  = ack_q;
  assign ovs_tick = ovs_tick_q;
  assign bit_tick = bit_tick_q;
  assign clkout   = clkout_q;
  assign div_err  = err_q;

endmodule

// File: tb/tb_iiitb_brg_prog.sv
// Directed bench for iiitb_brg_prog: edge counts between ticks, handshake timing, error flag, reset/enable.
module tb_iiitb_brg_prog;

  logic        clk = 1'b0;
  logic        reset, en, cfg_load;
  logic [1:0]  sel;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        cfg_busy, cfg_ack, ovs_tick, bit_tick, clkout, div_err;

  int total = 0;
  int bad   = 0;
  int n;
  int ticks;

  always #5 clk = ~clk;

  iiitb_brg_prog dut (
    .clk(clk), .reset(reset), .en(en), .sel(sel), .div_int(div_int), .div_frac(div_frac),
    .cfg_load(cfg_load), .cfg_busy(cfg_busy), .cfg_ack(cfg_ack), .ovs_tick(ovs_tick),
    .bit_tick(bit_tick), .clkout(clkout), .div_err(div_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return ovs_tick;
      1:       return bit_tick;
      2:       return cfg_ack;
      3:       return clkout;
      default: return !clkout;
    endcase
  endfunction

  // Edges until the chosen signal is seen high, bounded so a dead DUT still reaches the summary.
  task automatic wait_for(input int which, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!pick(which) && cnt < 400);
    if (!pick(which)) checkOutput("wait_timeout", 32'(pick(which)), 1);
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [15:0] i, input logic [3:0] f);
    sel      = s;
    div_int  = i;
    div_frac = f;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    sel      = 2'b11;
    div_int  = 16'd4;
    div_frac = 4'd0;
    cfg_load = 1'b0;
    step();
    step();
    checkOutput("rst_ovs", ovs_tick, 0);
    checkOutput("rst_clkout", clkout, 0);
    checkOutput("rst_busy", cfg_busy, 0);
    checkOutput("rst_err", div_err, 0);
    reset = 1'b0;

    // int=4 frac=0: 4 edges per tick, 64 per bit, 32 high / 32 low
    wait_for(0, n); checkOutput("t1_first_ovs", n, 4);
    wait_for(0, n); checkOutput("t1_second_ovs", n, 4);
    wait_for(1, n); checkOutput("t1_first_bit", n, 56);
    wait_for(3, n); checkOutput("t1_clk_low_half", n, 32);
    wait_for(4, n); checkOutput("t1_clk_high_half", n, 32);
    checkOutput("t1_bit_on_fall", bit_tick, 1);

    // load in the bit_tick cycle itself: applies at the following bit_tick
    applyStimulus(2'b11, 16'd4, 4'd8);
    checkOutput("t2_busy", cfg_busy, 1);
    wait_for(2, n); checkOutput("t2_ack_delay", n, 63);
    checkOutput("t2_ack_with_bit", bit_tick, 1);
    checkOutput("t2_busy_clear", cfg_busy, 0);
    wait_for(0, n); checkOutput("t2_per_a", n, 4);
    wait_for(0, n); checkOutput("t2_per_b", n, 5);
    wait_for(0, n); checkOutput("t2_per_c", n, 4);
    wait_for(1, n); checkOutput("t2_rest_of_bit", n, 59);
    wait_for(1, n); checkOutput("t2_full_bit", n, 72);

    // int=8 requested 10 edges into a bit
    repeat (9) step();
    applyStimulus(2'b11, 16'd8, 4'd0);
    checkOutput("t3_busy", cfg_busy, 1);
    wait_for(2, n); checkOutput("t3_ack_delay", n, 62);
    checkOutput("t3_ack_with_bit", bit_tick, 1);
    wait_for(1, n); checkOutput("t3_bit_128", n, 128);

    // illegal custom divisor clamps to 2 and sets the sticky error
    step();
    checkOutput("t4_err_before", div_err, 0);
    applyStimulus(2'b11, 16'd1, 4'd0);
    wait_for(2, n); checkOutput("t4_ack_delay", n, 126);
    checkOutput("t4_err_set", div_err, 1);
    wait_for(0, n); checkOutput("t4_clamped_per", n, 2);
    wait_for(0, n); checkOutput("t4_clamped_per2", n, 2);
    en = 1'b0;
    applyStimulus(2'b00, 16'd0, 4'd0);
    wait_for(2, n); checkOutput("t4_idle_ack", n, 1);
    checkOutput("t4_err_sticky", div_err, 1);
    checkOutput("t4_idle_clkout", clkout, 0);
    applyStimulus(2'b11, 16'd4, 4'd0);
    wait_for(2, n); checkOutput("t4_idle_ack2", n, 1);

    // enable gap mid-bit
    en = 1'b1;
    repeat (40) step();
    checkOutput("t6_clk_high", clkout, 1);
    en = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) checkOutput("t6_clk_drop", clkout, 0);
      ticks += int'(ovs_tick) + int'(bit_tick) + int'(clkout);
    end
    checkOutput("t6_no_activity", ticks, 0);
    en = 1'b1;
    wait_for(0, n); checkOutput("t6_restart", n, 4);

    // asynchronous reset between edges with a request pending; preset 2 after release
    repeat (36) step();
    checkOutput("t5_clk_high", clkout, 1);
    applyStimulus(2'b01, 16'd0, 4'd0);
    checkOutput("t5_busy", cfg_busy, 1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t5_async_clk", clkout, 0);
    checkOutput("t5_async_busy", cfg_busy, 0);
    sel = 2'b10;
    step();
    step();
    reset = 1'b0;
    wait_for(0, n); checkOutput("t5_preset_first", n, 27);
    wait_for(0, n); checkOutput("t5_preset_second", n, 27);
    checkOutput("t5_busy_discarded", cfg_busy, 0);
    checkOutput("t5_err_cleared", div_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
